// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command-driven sequencer for a bank of JK storage cells
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [7:0]       cmd_count,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_INVERT = 3'b011;
  localparam logic [2:0] OP_UP     = 3'b100;
  localparam logic [2:0] OP_DOWN   = 3'b101;
  localparam logic [2:0] OP_SHIFT  = 3'b110;
  localparam logic [2:0] OP_ROTATE = 3'b111;

  logic [1:0]       state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [8:0]       remaining;
  logic [WIDTH-1:0] t;
  logic             carry;
  logic             cmd_multi;

  assign cmd_ready = (state == ST_IDLE) && !clear;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign cmd_multi = (cmd_op == OP_HOLD) || cmd_op[2];

  always_comb begin
    j     = '0;
    k     = '0;
    t     = '0;
    carry = 1'b1;
    if (state == ST_RUN) begin
      case (op_r)
        OP_CLEAR:  k = '1;
        OP_LOAD:   begin j = data_r; k = ~data_r; end
        OP_INVERT: begin j = data_r; k = data_r; end
        // Ripple the toggle enable through the bank like a synchronous counter.
        OP_UP: begin
          for (int i = 0; i < WIDTH; i++) begin
            j[i]  = carry;
            k[i]  = carry;
            carry = carry & q[i];
          end
        end
        OP_DOWN: begin
          for (int i = 0; i < WIDTH; i++) begin
            j[i]  = carry;
            k[i]  = carry;
            carry = carry & ~q[i];
          end
        end
        OP_SHIFT:  begin t = {q[WIDTH-2:0], data_r[0]}; j = t; k = ~t; end
        OP_ROTATE: begin t = {q[WIDTH-2:0], q[WIDTH-1]}; j = t; k = ~t; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= ST_IDLE;
      q         <= '0;
      remaining <= '0;
      op_r      <= OP_HOLD;
      data_r    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r      <= cmd_op;
            data_r    <= cmd_data;
            remaining <= !cmd_multi ? 9'd1 :
                         (cmd_count == 8'd0) ? 9'd256 : {1'b0, cmd_count};
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          // JK rule per cell: set, reset, toggle or hold.
          q         <= (j & ~q) | (~k & q);
          remaining <= remaining - 9'd1;
          if (remaining == 9'd1) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - randomized self-checking bench for jk_bank_sequencer
module tb_jk_bank_sequencer;

  logic       clk = 1'b0;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_count;
  logic [3:0] j, k, q;
  logic       busy, done;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] mq;

  jk_bank_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .j(j), .k(k), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] next_q(input logic [2:0] op, input logic [3:0] d, input logic [3:0] cur);
    case (op)
      3'b000: return cur;
      3'b001: return 4'b0000;
      3'b010: return d;
      3'b011: return cur ^ d;
      3'b100: return cur + 4'd1;
      3'b101: return cur - 4'd1;
      3'b110: return {cur[2:0], d[0]};
      default: return {cur[2:0], cur[3]};
    endcase
  endfunction

  function automatic logic [7:0] exp_jk(input logic [2:0] op, input logic [3:0] d, input logic [3:0] cur);
    logic [3:0] nq;
    nq = next_q(op, d, cur);
    case (op)
      3'b000: return 8'h00;
      3'b001: return {4'b0000, 4'b1111};
      3'b011: return {d, d};
      3'b100, 3'b101: return {cur ^ nq, cur ^ nq};
      default: return {nq, ~nq};
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [7:0] cnt, input bit hold_valid);
    int waited = 0;
    cmd_op = op; cmd_data = d; cmd_count = cnt; cmd_valid = 1'b1;
    while (!cmd_ready && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    compared++;
    if (!cmd_ready) begin
      mismatched++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    if (!hold_valid) cmd_valid = 1'b0;
  endtask

  task automatic do_steps(input logic [2:0] op, input logic [3:0] d, input logic [7:0] cnt);
    int n;
    logic [7:0] ejk;
    n = (op == 3'b000 || op[2]) ? ((cnt == 8'd0) ? 256 : int'(cnt)) : 1;
    for (int s = 0; s < n; s++) begin
      ejk = exp_jk(op, d, mq);
      compared++;
      if ({j, k} !== ejk) begin
        mismatched++;
        $display("FAIL jk op=%0d step=%0d: got j=%b k=%b required j=%b k=%b", op, s, j, k, ejk[7:4], ejk[3:0]);
      end
      compared++;
      if ({busy, done, cmd_ready} !== 3'b100) begin
        mismatched++;
        $display("FAIL run_flags op=%0d step=%0d: busy/done/ready=%b required 100", op, s, {busy, done, cmd_ready});
      end
      @(posedge clk); #1;
      mq = next_q(op, d, mq);
      compared++;
      if (q !== mq) begin
        mismatched++;
        $display("FAIL q op=%0d step=%0d: got %b required %b", op, s, q, mq);
      end
    end
    compared++;
    if ({busy, done, cmd_ready, j, k} !== {3'b110, 8'h00}) begin
      mismatched++;
      $display("FAIL done_cycle op=%0d: busy/done/ready=%b j=%b k=%b required 110 0000 0000", op, {busy, done, cmd_ready}, j, k);
    end
    @(posedge clk); #1;
    compared++;
    if ({busy, done, cmd_ready, q} !== {3'b001, mq}) begin
      mismatched++;
      $display("FAIL idle_after op=%0d: busy/done/ready=%b q=%b required 001 q=%b", op, {busy, done, cmd_ready}, q, mq);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [3:0] d, input logic [7:0] cnt);
    issue(op, d, cnt, 1'b0);
    do_steps(op, d, cnt);
  endtask

  task automatic test_reset;
    clear = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b0; cmd_data = 4'b0; cmd_count = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({q, j, k, busy, done, cmd_ready} !== 15'd0) begin
      mismatched++;
      $display("FAIL reset_state: q=%b j=%b k=%b busy=%b done=%b ready=%b required all 0", q, j, k, busy, done, cmd_ready);
    end
    clear = 1'b0;
    #1;
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b required 1", cmd_ready);
    end
    mq = 4'b0000;
  endtask

  task automatic test_directed;
    run(3'b010, 4'b1010, 8'd1);
    run(3'b010, 4'b1110, 8'd1);
    run(3'b100, 4'b0000, 8'd3);
    run(3'b010, 4'b0001, 8'd1);
    run(3'b101, 4'b0000, 8'd2);
    run(3'b010, 4'b1010, 8'd1);
    run(3'b011, 4'b0110, 8'd1);
    run(3'b001, 4'b0000, 8'd1);
    run(3'b000, 4'b1111, 8'd3);
  endtask

  task automatic test_count_256;
    run(3'b001, 4'b0000, 8'd1);
    run(3'b100, 4'b0000, 8'd0);
    compared++;
    if (q !== 4'b0000) begin
      mismatched++;
      $display("FAIL count256_end: got %b required 0000", q);
    end
  endtask

  task automatic test_clear_mid;
    run(3'b001, 4'b0000, 8'd1);
    issue(3'b100, 4'b0000, 8'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (q !== 4'b0010) begin
      mismatched++;
      $display("FAIL clear_mid_pre: got %b required 0010", q);
    end
    clear = 1'b1;
    #1;
    compared++;
    if (cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_ready_low: got %b required 0", cmd_ready);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    mq = 4'b0000;
    #1;
    compared++;
    if ({q, busy, done, cmd_ready} !== 7'b0000_001) begin
      mismatched++;
      $display("FAIL clear_mid: q=%b busy=%b done=%b ready=%b required 0000 0 0 1", q, busy, done, cmd_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      compared++;
      if (done !== 1'b0 || q !== 4'b0000) begin
        mismatched++;
        $display("FAIL clear_no_done cycle=%0d: done=%b q=%b required 0 0000", c, done, q);
      end
    end
  endtask

  task automatic test_held_valid;
    issue(3'b010, 4'b1000, 8'd1, 1'b1);
    cmd_op = 3'b110; cmd_data = 4'b0001; cmd_count = 8'd2;
    do_steps(3'b010, 4'b1000, 8'd1);
    issue(3'b110, 4'b0001, 8'd2, 1'b1);
    cmd_op = 3'b010; cmd_data = 4'b1001; cmd_count = 8'd9;
    do_steps(3'b110, 4'b0001, 8'd2);
    issue(3'b010, 4'b1001, 8'd9, 1'b1);
    cmd_op = 3'b111; cmd_data = 4'b0110; cmd_count = 8'd1;
    do_steps(3'b010, 4'b1001, 8'd9);
    issue(3'b111, 4'b0110, 8'd1, 1'b0);
    do_steps(3'b111, 4'b0110, 8'd1);
    compared++;
    if (q !== 4'b0011) begin
      mismatched++;
      $display("FAIL rotate_result: got %b required 0011", q);
    end
  endtask

  task automatic test_random;
    logic [2:0] op;
    logic [3:0] d;
    logic [7:0] cnt;
    for (int n = 0; n < 60; n++) begin
      op  = 3'($urandom_range(0, 7));
      d   = 4'($urandom);
      cnt = 8'($urandom_range(1, 7));
      run(op, d, cnt);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_count_256();
    test_clear_mid();
    test_held_valid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

- Command-driven controller for a bank of WIDTH JK storage cells.
- Per-cell JK semantics: {j,k} = 00 hold, 01 reset, 10 set, 11 toggle.
- Accepts one command at a time over a valid/ready handshake and sequences the bank for one or more steps. Each step drives per-bit j/k vectors that realise load, clear, invert, synchronous up/down counting, shift or rotate. Signals completion with a one-cycle done pulse.
- The block owns the bank state q. j/k are exported for observability and for driving an external mirror bank.

## Interface
Parameters:
- WIDTH, default 4: number of JK cells in the bank; minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clear  input  1  reset; synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be accepted this cycle.
- cmd_op  input  3  operation code (see Operation).
- cmd_data  input  WIDTH  load value, toggle mask, or serial-in bit (bit 0).
- cmd_count  input  8  step count for multi-step ops; 0 means 256.
- j  output  WIDTH  per-cell J drive for the current cycle.
- k  output  WIDTH  per-cell K drive for the current cycle.
- q  output  WIDTH  bank state.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, RUN, DONE.
  - cmd_ready = (state==IDLE) && !clear.
  - busy = (state!=IDLE).
  - done = (state==DONE).
- **Accept:** occurs at an edge where cmd_valid && cmd_ready.
  - Latches op and data.
  - Sets remaining = 1 for single-step ops; remaining = cmd_count for multi-step ops, with 0 treated as 256 (9-bit counter).
  - Next state is RUN.
- **RUN:** j/k are combinational from latched op, latched data and current q. At each edge, q[i] updates per the JK rule and remaining decrements. When remaining==1 at the edge, next state is DONE.
- **DONE:** lasts one cycle with j=k=0, then returns to IDLE.
- **Outside RUN:** j=k=0; q holds.
- **Ops (step target t, drive j=t, k=~t unless noted):**
  - 000 HOLD, multi-step: j=k=0 for N cycles.
  - 001 CLEAR, single: j=0, k=all ones.
  - 010 LOAD, single: j=data, k=~data.
  - 011 INVERT, single: j=k=data; toggles masked bits.
  - 100 COUNT_UP, multi: j[i]=k[i]=&q[i-1:0]; bit 0 always toggles. Wraps all-ones to 0.
  - 101 COUNT_DOWN, multi: j[i]=k[i]=&~q[i-1:0]; bit 0 always toggles. Wraps 0 to all-ones.
  - 110 SHIFT_LEFT, multi: t={q[W-2:0], data[0]}.
  - 111 ROTATE_LEFT, multi: t={q[W-2:0], q[W-1]}.
- **cmd_valid while busy:** ignored. The requester must hold the command until cmd_ready; cmd fields may change freely while not accepted.
- **clear:** has priority over everything. At a clear edge: q=0, state=IDLE, remaining=0. Any in-flight command is dropped with no done pulse.

## Timing
- **Reset values:** q=0, j=0, k=0, busy=0, done=0, cmd_ready=0 while clear is high, cmd_ready=1 in the first cycle after clear deasserts.
- **Single-step op:** accept at edge E0; RUN during E0..E1; q updated at E1; done high E1..E2; cmd_ready high again after E2. Minimum command period is 3 cycles.
- **N-step op:** q updates at E1..EN; done high EN..EN+1. Total occupancy is N+2 cycles including the accept cycle.
- No back-to-back acceptance in DONE; a command held valid is accepted at the first IDLE edge.

## Test plan
- **Load:** clear, then LOAD data=4'b1010. Required: during RUN j=1010, k=0101; q=1010 at E1; done high exactly one cycle; busy low after E2.
- **Count up with wrap:** LOAD 1110, then COUNT_UP count=3. Required: q sequence 1111, 0000, 0001; done only after the third step.
- **Count down, then invert:** COUNT_DOWN count=2 from 0001. Required: 0000, then 1111. Then INVERT data=0110 on 1010. Required: q=1100.
- **Count-zero means 256:** COUNT_UP count=0 from 0000. Required: 256 RUN cycles; q back to 0000 at end; done on cycle 257 after accept.
- **Clear mid-operation:** clear asserted after 2 steps of COUNT_UP count=5 from 0000. Required: q=0000, no done pulse, cmd_ready=1 the cycle after clear drops.
- **Shift/rotate with held valid:** cmd_valid held high through busy. Required: no acceptance until IDLE. SHIFT_LEFT data[0]=1 count=2 from 1000 gives 0001 then 0011. ROTATE_LEFT count=1 from 1001 gives 0011.
